// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared frame layout, entry type and FSM encoding for the debug serial transmitter.
package debug_pkg;

  localparam int ADDR_BITS    = 5;
  localparam int DATA_BITS    = 32;
  localparam int PAYLOAD_BITS = ADDR_BITS + DATA_BITS;
  localparam int FRAME_BITS   = PAYLOAD_BITS + 3;

  localparam int START_POS  = 0;
  localparam int ADDR_POS   = START_POS + 1;
  localparam int DATA_POS   = ADDR_POS + ADDR_BITS;
  localparam int PARITY_POS = DATA_POS + DATA_BITS;
  localparam int STOP_POS   = PARITY_POS + 1;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic [ADDR_BITS-1:0] addr;
  } dbg_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  // Frame bit 0 goes on the line first; the shift register moves towards bit 0.
  function automatic logic [FRAME_BITS-1:0] build_frame(input dbg_entry_t e);
    logic [FRAME_BITS-1:0] f;
    f                         = '0;
    f[START_POS]              = 1'b0;
    f[ADDR_POS +: ADDR_BITS]  = e.addr;
    f[DATA_POS +: DATA_BITS]  = e.data;
    f[PARITY_POS]             = ^e;
    f[STOP_POS]               = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/debug_fifo.sv
// rtl/debug_fifo.sv - synchronous FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module debug_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             push_ok
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/debug_tx.sv
// rtl/debug_tx.sv - captures GPR writes into a FIFO and sends each as a 40-bit UART-style frame on debug_output.
module debug_tx
  import debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 4,
  parameter int FILTER_ZERO  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 debug_output,
  output logic                 busy,
  output logic                 overflow
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [5:0]        BIT_LAST  = 6'(FRAME_BITS - 1);

  tx_state_e             state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [5:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  overflow_q, overflow_d;

  logic                  capture;
  dbg_entry_t            entry_in;
  dbg_entry_t            head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      count_next;
  logic                  push_ok;
  logic                  pop_en;

  assign capture  = wr_en && ((FILTER_ZERO == 0) || (wr_addr != '0));
  assign entry_in = '{data: wr_data, addr: wr_addr};

  debug_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (entry_in),
    .pop       (pop_en),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .push_ok   (push_ok)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_en  = 1'b1;
          state_d = ST_SEND;
          shift_d = build_frame(head);
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      ST_SEND: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            // Chain straight into the next frame so bursts leave no idle gap.
            if (!fifo_empty) begin
              pop_en  = 1'b1;
              shift_d = build_frame(head);
              bit_d   = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_next = fifo_count + CNT_W'(push_ok) - CNT_W'(pop_en);
    tx_d       = (state_d == ST_SEND) ? shift_d[0] : 1'b1;
    busy_d     = (state_d == ST_SEND) || (count_next != '0);
    overflow_d = overflow_q || (capture && !push_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '1;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign debug_output = tx_q;
  assign busy         = busy_q;
  assign overflow     = overflow_q;

endmodule

// File: doc/debug_tx.md
# debug_tx

Serial transmitter behind the CPU's single-wire `debug_output` port. It captures every general-purpose register write from the GPR write port and buffers it in a small FIFO. Each buffered write is sent as a fixed 40-bit UART-style frame, so a bench-side receiver can rebuild the architectural write trace without probing internal signals. It is instantiated inside `mips`, next to `gpr`, and drives `debug_output` directly.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit, at least 1.
- `DEPTH`, default 4: FIFO entries; must be a power of two, at least 2.
- `FILTER_ZERO`, default 1: when 1, writes to register 0 are not captured.

Ports:
- `clk` input 1: the single clock; all logic is on its rising edge.
- `rst` input 1: reset, synchronous and active-low.
- `wr_en` input 1: GPR write strobe, one write per asserted cycle.
- `wr_addr` input 5: destination register index.
- `wr_data` input 32: value written.
- `debug_output` output 1: serial line, idle high.
- `busy` output 1: high while a frame is in flight or the FIFO is non-empty.
- `overflow` output 1: sticky; set when a write is dropped.

## Operation
- **Capture.**
  - A write is captured when `wr_en`=1 and (`FILTER_ZERO`=0 or `wr_addr`!=0).
  - The entry stored is {`wr_data`, `wr_addr`}, 37 bits.
- **Frame**, sent in this order, 40 bits:
  - start bit 0;
  - `wr_addr[0..4]`, LSB first;
  - `wr_data[0..31]`, LSB first;
  - even parity over the 37 payload bits (XOR of the payload);
  - stop bit 1.
- **FSM states.**
  - IDLE: line at 1.
    - Goes to SEND when the FIFO is non-empty.
    - On that transition, pops the head and loads the 40-bit shift register.
  - SEND: each bit is held for `CLKS_PER_BIT` cycles, then the register shifts.
    - After the stop bit has been held its full period, goes to IDLE if the FIFO is empty.
    - If the FIFO is not empty, goes straight back into SEND and pops the next entry, with no idle gap.
- **Bit counting.**
  - Bit counter is 6 bits, 0..39.
  - Baud counter is `$clog2(CLKS_PER_BIT)` bits wide, minimum 1.
- **FIFO.**
  - Occupancy counter is `$clog2(DEPTH)+1` bits.
  - Pointers wrap modulo `DEPTH`.
- **Full with no pop:** the new write is dropped and `overflow` is set. It stays set until reset.
- **Full with a pop in the same cycle:** the push is accepted and occupancy stays at `DEPTH`. `overflow` is not set.
- **Empty with a push:** the push lands first. The pop can happen at the earliest on the next cycle.
- **Reset** (`rst`=0 at a clock edge), including in the middle of a frame:
  - FIFO is emptied;
  - FSM goes to IDLE;
  - `debug_output`=1, `busy`=0, `overflow`=0.
  - A frame cut off by reset is never resumed.

## Timing
- All outputs come from registers; there are no combinational input-to-output paths.
- **Capture latency:** `wr_en` sampled at edge N puts the entry in the FIFO after edge N.
- **Start latency from idle:**
  - Edge N+1 pops the entry, loads the shift register and drives the start bit.
  - `debug_output` therefore goes low after edge N+1.
- **Frame duration:** 40×`CLKS_PER_BIT` cycles. The stop bit ends exactly 40×`CLKS_PER_BIT` cycles after the start bit's first cycle.
- **Back-to-back frames:** the next start bit follows the previous stop bit period immediately.
- **`busy`:**
  - Rises the cycle after the captured write.
  - Falls the cycle after the last stop-bit cycle, provided the FIFO is empty.
- **Sustainable rate:** one write per 40×`CLKS_PER_BIT` cycles. Burstier traffic relies on the `DEPTH` entries of buffering.

## Structure
- **Package `debug_pkg`:**
  - `FRAME_BITS`=40;
  - `PAYLOAD_BITS`=37;
  - frame-field offsets;
  - typedef `dbg_entry_t` (37 bits).
  - The bench-side receiver/decoder uses the same package.
- **Sub-module `debug_fifo`:** synchronous FIFO parameterised by width and `DEPTH`.
  - Push/pop ports, plus full/empty flags and the occupancy count.
  - Same `clk`/`rst`.
- **Top `debug_tx`:** capture filter, FSM, baud and bit counters, shift register, parity generator.

## Test plan
1. **Single frame.** `CLKS_PER_BIT`=4; one write, addr 5, data 0x0000_0001.
   - Line goes low 2 edges later.
   - Decoded payload is addr 5, data 1, parity 1 (three ones in the payload).
   - Stop bit is 1, frame is 160 cycles; `busy` then drops.
2. **Zero filter.** Write to addr 0, data 0xFFFF_FFFF, with `FILTER_ZERO`=1.
   - `debug_output` stays 1 and `busy` stays 0.
   - With `FILTER_ZERO`=0, a frame with addr 0 and parity 0 is sent.
3. **Burst and overflow.** `DEPTH`=4; 6 writes on consecutive cycles (addr 1..6).
   - Addrs 1..5 are transmitted back-to-back with no idle gap.
   - Addr 6 is dropped and `overflow`=1.
4. **Full with simultaneous pop.** Hold the FIFO full, then write in the exact cycle the next entry is popped.
   - The write is accepted and transmitted.
   - `overflow` stays 0.
5. **Reset mid-frame.** Assert `rst`=0 for 1 cycle during data bit 10.
   - Line returns to 1 and `busy`=0 the edge after reset; nothing further is sent.
   - A write afterwards sends a clean full frame.
